key_debounce_ctrl: RTL
======================

// Module: key_debounce_ctrl
// PURPOSE
//  Pushbutton front end feeding the key_flag input of the SPI flash command controllers (bulk erase, etc.).
//  Synchronises the raw active-low key, debounces press and release with a counter FSM, and emits
//  exactly one single-cycle key_flag per debounced press, so one press issues one flash command.
// PARAMETERS
//  CNT_MAX        999_999     debounce window minus 1, in sys_clk cycles (20 ms @ 50 MHz)
//  CNT_W          20          debounce counter width; must hold CNT_MAX
//  LONG_CNT_MAX   49_999_999  hold time minus 1 before first repeat (KEY_REPEAT_EN only, 1 s)
//  REP_CNT_MAX    9_999_999   repeat period minus 1 (KEY_REPEAT_EN only, 200 ms)
//  LONG_W         26          hold/repeat counter width; must hold LONG_CNT_MAX
// PORTS
//  sys_clk    in   1  system clock, 50 MHz
//  sys_rst_n  in   1  asynchronous active-low reset
//  key_in     in   1  raw pushbutton, 0 = pressed, asynchronous and bouncing
//  key_flag   out  1  one-cycle pulse per accepted press (to flash_*_ctrl key_flag)
//  key_state  out  1  debounced level, 1 = pressed
// BEHAVIOUR
//  Reset: sync FFs = 1 (released), state = IDLE, counters = 0, key_flag = 0, key_state = 0.
//  Sync: key_in -> ff1 -> ff2 (key_s). The FSM only ever reads key_s.
//  FSM (registered, 4 states):
//   IDLE:    key_s == 0 -> PRESS_DB, cnt <= 0.
//   PRESS_DB: key_s == 1 -> IDLE, cnt <= 0 (bounce, no flag).
//            key_s == 0 and cnt != CNT_MAX -> cnt + 1.
//            key_s == 0 and cnt == CNT_MAX -> PRESSED; key_flag <= 1 and key_state <= 1 on the same edge.
//   PRESSED: key_s == 1 -> RELEASE_DB, cnt <= 0.
//   RELEASE_DB: key_s == 0 -> PRESSED, cnt <= 0 (bounce, no new flag).
//              key_s == 1 and cnt == CNT_MAX -> IDLE, key_state <= 0; else cnt + 1.
//  key_flag is a registered output. It is high for exactly 1 cycle and never high on two consecutive cycles.
//  Latency: count the first edge that samples key_in low as edge 1. Sampling continues low.
//   key_flag/key_state rise at edge CNT_MAX+4. Release: key_state falls at edge CNT_MAX+4 of the stable-high run.
//  Any low run on key_s shorter than CNT_MAX+2 cycles produces no flag.
//  Counter arithmetic: unsigned, no wrap. cnt is compared with == CNT_MAX and cleared on every state change.
//  Reset mid-operation: everything returns to reset values immediately, and any pending pulse is dropped.
//   If the key is still held after reset release, it is re-debounced and a new key_flag is issued (CNT_MAX+4 edges).
// CONFIGURATION
//  KEY_REPEAT_EN defined:
//   - In PRESSED a hold counter runs.
//   - At LONG_CNT_MAX it pulses key_flag for 1 cycle.
//   - After that it pulses every REP_CNT_MAX+1 cycles while the state is PRESSED.
//   - The hold counter clears on entering PRESSED, including a return from RELEASE_DB.
//   - The hold counter is frozen in RELEASE_DB.
//  KEY_REPEAT_EN undefined: the hold counter and LONG_*/REP_* logic are absent. Exactly one flag per press.
// TESTING (bench overrides CNT_MAX=9, LONG_CNT_MAX=19, REP_CNT_MAX=4; 20 ns clock)
//  1. Reset held, key_in=1 -> key_flag=0, key_state=0. Reset releases at 30 ns -> outputs stay 0.
//  2. key_in=0 held 40 cycles -> one key_flag pulse at edge 13, width 1 cycle; key_state=1 from edge 13.
//  3. key_in toggles every 3 cycles for 30 cycles, then stays low -> exactly one key_flag, 13 edges after the last fall.
//  4. key_in low for 8 cycles, then high -> no key_flag; key_state stays 0.
//  5. Release with 4 bounces of 2 cycles -> no extra key_flag; key_state=0 at edge 13 of the stable-high run.
//  6. Reset asserted while PRESSED, key held -> outputs 0 at once; after release, key_flag again at edge 13.
//  7. With KEY_REPEAT_EN, hold 60 cycles past the first flag -> extra pulses at +20, +25, +30 ... cycles.

Source files
------------

// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl: synchronises and debounces an active-low pushbutton, one key_flag pulse per press.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module key_debounce_ctrl #(
  parameter int CNT_MAX      = 999_999,
  parameter int CNT_W        = 20
`ifdef KEY_REPEAT_EN
  ,
  parameter int LONG_CNT_MAX = 49_999_999,
  parameter int REP_CNT_MAX  = 9_999_999,
  parameter int LONG_W       = 26
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);
  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(CNT_MAX);
  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d, kst_q, kst_d;
  logic             key_s;
  assign key_s     = sync_q[1];
  assign key_flag  = flag_q;
  assign key_state = kst_q;
`ifdef KEY_REPEAT_EN
  localparam logic [LONG_W-1:0] LMAX   = LONG_W'(LONG_CNT_MAX);
  localparam logic [LONG_W-1:0] RELOAD = LONG_W'(LONG_CNT_MAX - REP_CNT_MAX);
  logic [LONG_W-1:0] hold_q, hold_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = 1'b0;
    kst_d   = kst_q;
    case (state_q)
      IDLE: if (!key_s) begin
        state_d = PRESS_DB;
        cnt_d   = '0;
      end
      PRESS_DB: if (key_s) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (cnt_q == CMAX) begin
        state_d = PRESSED;
        cnt_d   = '0;
        flag_d  = 1'b1;
        kst_d   = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      PRESSED: if (key_s) begin
        state_d = RELEASE_DB;
        cnt_d   = '0;
      end
      RELEASE_DB: if (!key_s) begin
        state_d = PRESSED;
        cnt_d   = '0;
      end else if (cnt_q == CMAX) begin
        state_d = IDLE;
        cnt_d   = '0;
        kst_d   = 1'b0;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
`ifdef KEY_REPEAT_EN
    hold_d = hold_q;
    // reloading to LMAX-RMAX makes every later repeat land REP_CNT_MAX+1 cycles apart
    if (state_q == PRESSED && !key_s) begin
      flag_d = hold_q == LMAX;
      hold_d = (hold_q == LMAX) ? RELOAD : hold_q + 1'b1;
    end
    if (state_d == PRESSED && state_q != PRESSED) hold_d = '0;
`endif
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      kst_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
      hold_q  <= '0;
`endif
    end else begin
      sync_q  <= {sync_q[0], key_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      kst_q   <= kst_d;
`ifdef KEY_REPEAT_EN
      hold_q  <= hold_d;
`endif
    end
  end
endmodule
